// File: rtl/deco_pkg.sv
// Shared types and helpers for the deco_phase_seq one-hot phase decoder.
package deco_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_BLANKING = 2'd2
  } state_t;

  localparam int BLANK_CNT_W  = 4;
  // Largest select width the onehot helper supports; callers truncate to 2^SEL_W.
  localparam int MAX_SEL_W    = 8;
  localparam int ONEHOT_MAX_W = 1 << MAX_SEL_W;

  function automatic logic [ONEHOT_MAX_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
    return ONEHOT_MAX_W'(1) << idx;
  endfunction

endpackage

// File: rtl/deco_phase_seq_phase_timer.sv
// Loadable down-counter used for both the dwell and the blanking intervals.
module phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] load_val,
  output logic         expire,
  output logic         busy
);

  logic [W-1:0] cnt_r;

  // Counter: reload on start, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (start) begin
      cnt_r <= load_val;
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // expire marks the last cycle of an interval loaded with value N.
  assign expire = (cnt_r == W'(1));
  assign busy   = (cnt_r != '0);

endmodule

// File: rtl/deco_phase_seq.sv
// Registered N-to-2^N one-hot phase decoder with sequencer mode and
// break-before-make blanking between different active outputs.
module deco_phase_seq
  import deco_pkg::*;
#(
  parameter int SEL_W   = 2,
  parameter int BLANK   = 1,
  parameter int DWELL_W = 8
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    EN,
  input  logic                    MODE,
  input  logic                    LOAD,
  input  logic [SEL_W-1:0]        IN,
  input  logic [DWELL_W-1:0]      DWELL,
  output logic [(1<<SEL_W)-1:0]   OUT,
  output logic [SEL_W-1:0]        IDX,
  output logic                    WRAP
);

  localparam int OUT_W = 1 << SEL_W;
  localparam logic [BLANK_CNT_W-1:0] BLANK_LD = BLANK_CNT_W'(BLANK);
  localparam logic [SEL_W-1:0]       IDX_LAST = '1;

  state_t             state_r, state_n;
  logic [SEL_W-1:0]   idx_r, idx_n;
  logic [OUT_W-1:0]   out_r, out_n;
  logic               wrap_r, wrap_n;
  logic               wrap_pend_r, wrap_pend_n;

  logic               dwell_start_s, dwell_expire_s, dwell_busy_s, dwell_done_s;
  logic               blank_start_s, blank_expire_s, blank_busy_s, blank_done_s;
  logic [DWELL_W-1:0] dwell_ld_s;

  assign dwell_ld_s = (DWELL == '0) ? DWELL_W'(1) : DWELL;
  // A counter already at zero also ends the interval, so the FSM can never stall.
  assign dwell_done_s = dwell_expire_s | ~dwell_busy_s;
  assign blank_done_s = blank_expire_s | ~blank_busy_s;

  phase_timer #(.W(DWELL_W)) u_dwell (
    .clk      (CLK),
    .rst_n    (RST_N),
    .start    (dwell_start_s),
    .load_val (dwell_ld_s),
    .expire   (dwell_expire_s),
    .busy     (dwell_busy_s)
  );

  phase_timer #(.W(BLANK_CNT_W)) u_blank (
    .clk      (CLK),
    .rst_n    (RST_N),
    .start    (blank_start_s),
    .load_val (BLANK_LD),
    .expire   (blank_expire_s),
    .busy     (blank_busy_s)
  );

  // Next-state, index and wrap decisions.
  always_comb begin
    state_n       = state_r;
    idx_n         = idx_r;
    wrap_n        = 1'b0;
    wrap_pend_n   = wrap_pend_r;
    dwell_start_s = 1'b0;
    blank_start_s = 1'b0;
    if (!EN) begin
      state_n     = ST_IDLE;
      wrap_pend_n = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // OUT is already zero, so entry needs no blanking.
          if (LOAD) begin
            idx_n = IN;
          end else begin
            idx_n = idx_r;
          end
          state_n       = ST_ACTIVE;
          dwell_start_s = 1'b1;
          wrap_pend_n   = 1'b0;
        end
        ST_ACTIVE: begin
          if (LOAD && (IN != idx_r)) begin
            idx_n = IN;
            if (BLANK == 0) begin
              dwell_start_s = 1'b1;
            end else begin
              state_n       = ST_BLANKING;
              blank_start_s = 1'b1;
            end
          end else if (LOAD || !MODE) begin
            // Direct mode keeps the dwell timer primed so a switch to sequence starts fresh.
            dwell_start_s = 1'b1;
          end else if (dwell_done_s) begin
            idx_n = idx_r + SEL_W'(1);
            if (BLANK == 0) begin
              dwell_start_s = 1'b1;
              wrap_n        = (idx_r == IDX_LAST);
            end else begin
              state_n       = ST_BLANKING;
              blank_start_s = 1'b1;
              wrap_pend_n   = (idx_r == IDX_LAST);
            end
          end else begin
            dwell_start_s = 1'b0;
          end
        end
        ST_BLANKING: begin
          if (LOAD) begin
            idx_n       = IN;
            wrap_pend_n = 1'b0;
          end else begin
            idx_n = idx_r;
          end
          if (blank_done_s) begin
            state_n       = ST_ACTIVE;
            dwell_start_s = 1'b1;
            wrap_n        = wrap_pend_n & MODE;
            wrap_pend_n   = 1'b0;
          end else begin
            state_n = ST_BLANKING;
          end
        end
        default: begin
          state_n     = ST_IDLE;
          wrap_pend_n = 1'b0;
        end
      endcase
    end
  end

  // Output decode from the next state so OUT is a pure register.
  always_comb begin
    out_n = '0;
    if (state_n == ST_ACTIVE) begin
      out_n = OUT_W'(onehot(MAX_SEL_W'(idx_n)));
    end else begin
      out_n = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r     <= ST_IDLE;
      idx_r       <= '0;
      out_r       <= '0;
      wrap_r      <= 1'b0;
      wrap_pend_r <= 1'b0;
    end else begin
      state_r     <= state_n;
      idx_r       <= idx_n;
      out_r       <= out_n;
      wrap_r      <= wrap_n;
      wrap_pend_r <= wrap_pend_n;
    end
  end

  assign OUT  = out_r;
  assign IDX  = idx_r;
  assign WRAP = wrap_r;

endmodule

// File: tb/tb_deco_phase_seq.sv
// Directed self-checking bench for deco_phase_seq (BLANK = 1, 2 and 0 instances).
module tb_deco_phase_seq;

  logic       CLK;
  logic       RST_N;
  logic       EN;
  logic       MODE;
  logic       LOAD;
  logic [1:0] in_sel;
  logic [7:0] dwell;

  logic [3:0] out_b1, out_b2, out_b0;
  logic [1:0] idx_b1, idx_b2, idx_b0;
  logic       wrap_b1, wrap_b2, wrap_b0;

  int n_tests = 0;
  int n_fail  = 0;
  logic mon_on = 1'b0;

  deco_phase_seq #(.SEL_W(2), .BLANK(1), .DWELL_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .MODE(MODE), .LOAD(LOAD),
    .IN(in_sel), .DWELL(dwell), .OUT(out_b1), .IDX(idx_b1), .WRAP(wrap_b1)
  );

  deco_phase_seq #(.SEL_W(2), .BLANK(2), .DWELL_W(8)) dut_b2 (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .MODE(MODE), .LOAD(LOAD),
    .IN(in_sel), .DWELL(dwell), .OUT(out_b2), .IDX(idx_b2), .WRAP(wrap_b2)
  );

  deco_phase_seq #(.SEL_W(2), .BLANK(0), .DWELL_W(8)) dut_b0 (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .MODE(MODE), .LOAD(LOAD),
    .IN(in_sel), .DWELL(dwell), .OUT(out_b0), .IDX(idx_b0), .WRAP(wrap_b0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // At most one phase output high on every cycle, for every instance.
  always @(negedge CLK) begin
    if (mon_on) begin
      check("onehot_b1", 32'($countones(out_b1) <= 1), 32'd1);
      check("onehot_b2", 32'($countones(out_b2) <= 1), 32'd1);
      check("onehot_b0", 32'($countones(out_b0) <= 1), 32'd1);
    end
  end

  logic [3:0] seq_exp [22] = '{
    4'b0001, 4'b0001, 4'b0001, 4'b0000,
    4'b0010, 4'b0010, 4'b0010, 4'b0000,
    4'b0100, 4'b0100, 4'b0100, 4'b0000,
    4'b1000, 4'b1000, 4'b1000, 4'b0000,
    4'b0001, 4'b0001, 4'b0001, 4'b0000,
    4'b0010, 4'b0010
  };

  initial begin
    RST_N = 1'b0; EN = 1'b1; MODE = 1'b0; LOAD = 1'b1; in_sel = 2'd2; dwell = 8'd3;

    // Reset held two cycles with EN and LOAD active
    tick();
    mon_on = 1'b1;
    tick();
    check("rst_out", 32'(out_b1), 32'h0);
    check("rst_idx", 32'(idx_b1), 32'h0);
    check("rst_wrap", 32'(wrap_b1), 32'h0);
    RST_N = 1'b1; LOAD = 1'b0;
    tick();
    check("rel_out", 32'(out_b1), 32'b0001);

    // Direct mode: load 2, blank one cycle, then hold on repeated load
    LOAD = 1'b1; in_sel = 2'd2;
    tick();
    check("dir_blank", 32'(out_b1), 32'b0000);
    LOAD = 1'b0;
    tick();
    check("dir_out", 32'(out_b1), 32'b0100);
    check("dir_idx", 32'(idx_b1), 32'd2);
    LOAD = 1'b1; in_sel = 2'd2;
    tick();
    check("dir_same1", 32'(out_b1), 32'b0100);
    LOAD = 1'b0;
    tick();
    check("dir_same2", 32'(out_b1), 32'b0100);

    // Sequence mode from index 0, DWELL=3, BLANK=1
    RST_N = 1'b0; MODE = 1'b1; dwell = 8'd3;
    tick();
    RST_N = 1'b1;
    for (int i = 0; i < 22; i++) begin
      tick();
      check($sformatf("seq_out[%0d]", i), 32'(out_b1), 32'(seq_exp[i]));
      check($sformatf("seq_wrap[%0d]", i), 32'(wrap_b1), (i == 16) ? 32'd1 : 32'd0);
    end

    // EN drop on 2nd cycle of 0010, then restore
    EN = 1'b0;
    tick();
    check("en0_out", 32'(out_b1), 32'b0000);
    check("en0_idx", 32'(idx_b1), 32'd1);
    tick();
    check("en0_hold", 32'(idx_b1), 32'd1);
    EN = 1'b1;
    tick();
    check("en1_c1", 32'(out_b1), 32'b0010);
    tick();
    check("en1_c2", 32'(out_b1), 32'b0010);
    tick();
    check("en1_c3", 32'(out_b1), 32'b0010);
    tick();
    check("en1_blank", 32'(out_b1), 32'b0000);
    tick();
    check("en1_next", 32'(out_b1), 32'b0100);

    // LOAD during blanking on the BLANK=2 instance
    RST_N = 1'b0; MODE = 1'b0; LOAD = 1'b0;
    tick();
    RST_N = 1'b1;
    tick();
    check("b2_start", 32'(out_b2), 32'b0001);
    LOAD = 1'b1; in_sel = 2'd1;
    tick();
    check("b2_blank1", 32'(out_b2), 32'b0000);
    check("b2_pend1", 32'(idx_b2), 32'd1);
    in_sel = 2'd3;
    tick();
    check("b2_blank2", 32'(out_b2), 32'b0000);
    check("b2_pend3", 32'(idx_b2), 32'd3);
    LOAD = 1'b0;
    tick();
    check("b2_new", 32'(out_b2), 32'b1000);
    tick();
    check("b2_hold", 32'(out_b2), 32'b1000);

    // BLANK=0 with DWELL=0: one phase per cycle, wrap on return to 0
    RST_N = 1'b0; MODE = 1'b1; dwell = 8'd0;
    tick();
    RST_N = 1'b1;
    tick();
    check("b0_p0", 32'(out_b0), 32'b0001);
    check("b0_w0", 32'(wrap_b0), 32'd0);
    tick();
    check("b0_p1", 32'(out_b0), 32'b0010);
    tick();
    check("b0_p2", 32'(out_b0), 32'b0100);
    tick();
    check("b0_p3", 32'(out_b0), 32'b1000);
    tick();
    check("b0_wrap_out", 32'(out_b0), 32'b0001);
    check("b0_wrap", 32'(wrap_b0), 32'd1);
    tick();
    check("b0_after", 32'(out_b0), 32'b0010);
    check("b0_wrap_end", 32'(wrap_b0), 32'd0);

    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/deco_phase_seq.md
# deco_phase_seq

Parametrised, registered N-to-2^N one-hot phase decoder for the DPWM output stage. It generalises the 2-to-4 decoder in two ways: `SEL_W` sets the input width, and it adds a sequencer mode. In direct mode it drives one selected output. In sequence mode it steps the one-hot output through every phase with programmable dwell time. Every change of active output uses break-before-make blanking, so two phase outputs are never high in the same cycle.

## Interface
- `SEL_W`, default 2: select width; `OUT` is 2^`SEL_W` bits.
- `BLANK`, default 1, legal range 0..15: all-zero cycles inserted between two different active outputs.
- `DWELL_W`, default 8: width of `DWELL`.

- `CLK`  in  1  single clock; all logic on rising edge.
- `RST_N`  in  1  synchronous, active-low reset.
- `EN`  in  1  1 = outputs may be active; 0 = `OUT` forced to zero.
- `MODE`  in  1  0 = direct decode; 1 = sequence.
- `LOAD`  in  1  one-cycle strobe; captures `IN`.
- `IN`  in  `SEL_W`  target index (direct) or start index (sequence).
- `DWELL`  in  `DWELL_W`  active cycles per phase in sequence mode; 0 treated as 1.
- `OUT`  out  2^`SEL_W`  registered one-hot output, or all zero.
- `IDX`  out  `SEL_W`  registered current/pending index.
- `WRAP`  out  1  one-cycle pulse on the first cycle `OUT[0]` is active after advancing from the last index.

## Operation
- **Reset:** `RST_N`=0 at an edge gives `OUT`=0, `IDX`=0, `WRAP`=0, state IDLE, both counters 0. Reset overrides all other inputs, including mid-blank and mid-dwell.
- **States:**
  - IDLE: `OUT`=0.
  - ACTIVE: `OUT`=onehot(`IDX`).
  - BLANKING: `OUT`=0, blank counter running.
- **IDLE transitions:**
  - On `EN`=1 it goes to ACTIVE with the current `IDX`; no blanking, because `OUT` is already zero.
  - If `LOAD`=1 in the same cycle, `IDX`←`IN` first.
- **EN=0:** from any state, go to IDLE next cycle. `IDX` is held. `LOAD` is ignored while `EN`=0.
- **Direct mode, ACTIVE:**
  - `LOAD` with `IN`≠`IDX`: `IDX`←`IN`, go to BLANKING, or straight to ACTIVE with the new index if `BLANK`=0.
  - `LOAD` with `IN`=`IDX`: no effect.
- **Sequence mode, ACTIVE:**
  - The dwell counter counts cycles in the phase.
  - After max(`DWELL`,1) cycles: `IDX`←`IDX`+1 (mod 2^`SEL_W`, wraps from all-ones to 0), then BLANKING.
  - `LOAD`: `IDX`←`IN`, dwell counter restarts. Blanking applies only if the index changed.
- **BLANKING:**
  - Lasts exactly `BLANK` cycles, then ACTIVE with the pending `IDX`.
  - A `LOAD` during BLANKING replaces the pending `IDX`. The blank counter is not restarted.
- **Mode switching:** `MODE` is sampled every cycle.
  - 1→0 freezes on the current `IDX`; dwell counting stops.
  - 0→1 starts dwell counting from 0 at the current `IDX`.
- **`WRAP`:** asserted only in sequence mode, together with the ACTIVE cycle following the index advance from 2^`SEL_W`−1 to 0. It is not asserted for a `LOAD` to 0.
- **Widths:** the dwell counter is `DWELL_W` bits; the blank counter is 4 bits.

## Timing
- All outputs are registered.
- `LOAD` at edge t, index change, `BLANK`=B:
  - `OUT`=0 on cycles t+1..t+B.
  - New one-hot from t+1+B.
  - With B=0, the new one-hot appears at t+1.
- `EN` fall at edge t gives `OUT`=0 at t+1. `EN` rise at edge t gives the one-hot at t+1.
- Sequence period = 2^`SEL_W`·(max(`DWELL`,1)+`BLANK`) cycles.
- Invariant: popcount(`OUT`)≤1 on every cycle.

## Structure
- Package `deco_pkg`: state enum (IDLE, ACTIVE, BLANKING), 4-bit blank-counter width constant, and function `onehot(idx)` returning a 2^`SEL_W` vector.
- One sub-module, `phase_timer`: a loadable down-counter shared by the dwell and blank intervals. Inputs are load value and start; outputs are expire and busy.
- The FSM and output registers live in `deco_phase_seq`.

## Test plan
All scenarios use `SEL_W`=2, `BLANK`=1, `DWELL`=3 unless stated.
- **Reset:** hold `RST_N`=0 for 2 cycles with `EN`=1 and `LOAD`=1 → `OUT`=0000, `IDX`=0, `WRAP`=0. Release → `OUT`=0001 next cycle.
- **Direct mode, `EN`=1, `MODE`=0:** `LOAD` `IN`=2 from 0001 at t → `OUT`=0000 at t+1, 0100 at t+2. `LOAD` `IN`=2 again → `OUT` stays 0100.
- **Sequence mode from `IDX`=0:** `OUT` repeats 0001×3, 0000, 0010×3, 0000, 0100×3, 0000, 1000×3, 0000, then 0001 with `WRAP`=1 for that single cycle. Period is 16 cycles.
- **EN drop and restore:** `EN`=0 on the 2nd cycle of 0010 → `OUT`=0000 next cycle, `IDX`=1 held. `EN`=1 → 0010 for a full 3 cycles.
- **LOAD during blanking, `BLANK`=2, direct mode:** `LOAD` `IN`=1 then `LOAD` `IN`=3 on the next cycle → `OUT`=0000, 0000, then 1000; 0010 never appears.
- **Edge cases:** `BLANK`=0 with `DWELL`=0 → `OUT` steps 0001, 0010, 0100, 1000 on consecutive cycles. Across all scenarios, check popcount(`OUT`)≤1 on every cycle.
